// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control unit: one state per cycle, memory states stretch
// until mem_ready, datapath controls decoded from the current state.
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] alucontrol,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       memread,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t r_state;
    state_t w_next;

    // State register; synchronous active-low reset returns to FETCH.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and output decode; write enables are gated off during reset.
    always_comb begin
        w_next     = r_state;
        alucontrol = 3'b000;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        pcen       = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        memread    = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        illegal    = 1'b0;

        case (r_state)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                pcsrc   = 2'b00;
                irwrite = mem_ready;
                pcen    = mem_ready;
                if (mem_ready) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default: begin
                        w_next  = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                memread = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                w_next   = S_FETCH;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                if (mem_ready) begin
                    w_next = S_FETCH;
                end
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                alusrcb = 2'b00;
                w_next  = S_ALUWB;
                case (funct)
                    6'b100000: alucontrol = 3'b000;
                    6'b100010: alucontrol = 3'b001;
                    6'b100100: alucontrol = 3'b010;
                    6'b100101: alucontrol = 3'b110;
                    6'b101010: alucontrol = 3'b111;
                    default: begin
                        illegal = 1'b1;
                        w_next  = S_FETCH;
                    end
                endcase
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = 3'b001;
                pcsrc      = 2'b01;
                pcen       = zero;
                w_next     = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = 3'b000;
                w_next     = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_JUMP: begin
                pcsrc  = 2'b10;
                pcen   = 1'b1;
                w_next = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        if (!reset_n) begin
            pcen     = 1'b0;
            irwrite  = 1'b0;
            memwrite = 1'b0;
            memread  = 1'b0;
            regwrite = 1'b0;
            illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class
// cycle by cycle and compares the full control vector against constants.
module tb_mips_multicycle_ctrl;

    logic       clk;
    logic       reset_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [2:0] alucontrol;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       memread;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       illegal;

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;
    int t0;

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .alucontrol (alucontrol),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .pcen       (pcen),
        .iord       (iord),
        .irwrite    (irwrite),
        .memwrite   (memwrite),
        .memread    (memread),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle counter used for instruction-length checks.
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Pack: {alucontrol, alusrca, alusrcb, pcsrc, pcen, iord, irwrite,
    //        memwrite, memread, regwrite, regdst, memtoreg, illegal}
    function automatic logic [17:0] mk(input logic [2:0] alc, input logic asa,
                                       input logic [1:0] asb, input logic [1:0] pcs,
                                       input logic pce, input logic ior, input logic irw,
                                       input logic mw, input logic mr, input logic rw,
                                       input logic rd, input logic m2r, input logic ill);
        return {alc, asa, asb, pcs, pce, ior, irw, mw, mr, rw, rd, m2r, ill};
    endfunction

    logic [17:0] outs;
    assign outs = {alucontrol, alusrca, alusrcb, pcsrc, pcen, iord, irwrite,
                   memwrite, memread, regwrite, regdst, memtoreg, illegal};

    // Expected vectors per state, written out by hand.
    logic [17:0] E_RST_FETCH, E_FETCH_RDY, E_FETCH_WAIT, E_DECODE, E_DECODE_ILL,
                 E_MEMADR, E_MEMRD, E_MEMWB, E_MEMWR, E_MEMWR_RST, E_ALUWB,
                 E_BR_TAKEN, E_BR_NOT, E_ADDIEX, E_ADDIWB, E_JUMP, E_EXEC_ILL;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Compare outputs mid-cycle, then advance to just after the next edge.
    task automatic cyc(input string tag, input logic [17:0] exp);
        #2;
        check(tag, {14'd0, outs}, {14'd0, exp});
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] e_exec(input logic [2:0] alc);
        return mk(alc, 1'b1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    initial begin
        E_RST_FETCH  = mk(3'b000, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_FETCH_RDY  = mk(3'b000, 0, 2'b01, 2'b00, 1, 0, 1, 0, 1, 0, 0, 0, 0);
        E_FETCH_WAIT = mk(3'b000, 0, 2'b01, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        E_DECODE     = mk(3'b000, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_DECODE_ILL = mk(3'b000, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        E_MEMADR     = mk(3'b000, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_MEMRD      = mk(3'b000, 0, 2'b00, 2'b00, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        E_MEMWB      = mk(3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        E_MEMWR      = mk(3'b000, 0, 2'b00, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        E_MEMWR_RST  = mk(3'b000, 0, 2'b00, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        E_ALUWB      = mk(3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        E_BR_TAKEN   = mk(3'b001, 1, 2'b00, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        E_BR_NOT     = mk(3'b001, 1, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_ADDIEX     = mk(3'b000, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_ADDIWB     = mk(3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        E_JUMP       = mk(3'b000, 0, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        E_EXEC_ILL   = mk(3'b000, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        reset_n   = 1'b0;
        mem_ready = 1'b1;
        op        = 6'b000000;
        funct     = 6'b100000;
        zero      = 1'b0;

        // Reset held for three cycles: all enables low.
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cyc("reset_hold", E_RST_FETCH);
        reset_n = 1'b1;

        // add
        t0 = cyc_n;
        op = 6'b000000; funct = 6'b100000;
        cyc("add_fetch", E_FETCH_RDY);
        cyc("add_decode", E_DECODE);
        cyc("add_exec", e_exec(3'b000));
        cyc("add_aluwb", E_ALUWB);
        check("add_cycles", cyc_n - t0, 4);

        // slt
        t0 = cyc_n;
        funct = 6'b101010;
        cyc("slt_fetch", E_FETCH_RDY);
        cyc("slt_decode", E_DECODE);
        cyc("slt_exec", e_exec(3'b111));
        cyc("slt_aluwb", E_ALUWB);
        check("slt_cycles", cyc_n - t0, 4);

        // sub / and / or execute encodings
        funct = 6'b100010;
        cyc("sub_fetch", E_FETCH_RDY);
        cyc("sub_decode", E_DECODE);
        cyc("sub_exec", e_exec(3'b001));
        cyc("sub_aluwb", E_ALUWB);
        funct = 6'b100100;
        cyc("and_fetch", E_FETCH_RDY);
        cyc("and_decode", E_DECODE);
        cyc("and_exec", e_exec(3'b010));
        cyc("and_aluwb", E_ALUWB);
        funct = 6'b100101;
        cyc("or_fetch", E_FETCH_RDY);
        cyc("or_decode", E_DECODE);
        cyc("or_exec", e_exec(3'b110));
        cyc("or_aluwb", E_ALUWB);

        // lw with two wait cycles in FETCH and in MEMRD
        t0 = cyc_n;
        op = 6'b100011;
        mem_ready = 1'b0;
        cyc("lw_fetch_w1", E_FETCH_WAIT);
        cyc("lw_fetch_w2", E_FETCH_WAIT);
        mem_ready = 1'b1;
        cyc("lw_fetch", E_FETCH_RDY);
        cyc("lw_decode", E_DECODE);
        cyc("lw_memadr", E_MEMADR);
        mem_ready = 1'b0;
        cyc("lw_memrd_w1", E_MEMRD);
        cyc("lw_memrd_w2", E_MEMRD);
        mem_ready = 1'b1;
        cyc("lw_memrd", E_MEMRD);
        cyc("lw_memwb", E_MEMWB);
        check("lw_cycles", cyc_n - t0, 9);

        // sw, no waits
        t0 = cyc_n;
        op = 6'b101011;
        cyc("sw_fetch", E_FETCH_RDY);
        cyc("sw_decode", E_DECODE);
        cyc("sw_memadr", E_MEMADR);
        cyc("sw_memwr", E_MEMWR);
        check("sw_cycles", cyc_n - t0, 4);

        // beq taken and not taken
        t0 = cyc_n;
        op = 6'b000100; zero = 1'b1;
        cyc("beq1_fetch", E_FETCH_RDY);
        cyc("beq1_decode", E_DECODE);
        cyc("beq1_branch", E_BR_TAKEN);
        check("beq1_cycles", cyc_n - t0, 3);
        t0 = cyc_n;
        zero = 1'b0;
        cyc("beq0_fetch", E_FETCH_RDY);
        cyc("beq0_decode", E_DECODE);
        cyc("beq0_branch", E_BR_NOT);
        check("beq0_cycles", cyc_n - t0, 3);

        // addi
        t0 = cyc_n;
        op = 6'b001000;
        cyc("addi_fetch", E_FETCH_RDY);
        cyc("addi_decode", E_DECODE);
        cyc("addi_ex", E_ADDIEX);
        cyc("addi_wb", E_ADDIWB);
        check("addi_cycles", cyc_n - t0, 4);

        // j
        t0 = cyc_n;
        op = 6'b000010;
        cyc("j_fetch", E_FETCH_RDY);
        cyc("j_decode", E_DECODE);
        cyc("j_jump", E_JUMP);
        check("j_cycles", cyc_n - t0, 3);

        // illegal opcode: pulse in DECODE, straight back to FETCH
        op = 6'b111111;
        cyc("illop_fetch", E_FETCH_RDY);
        cyc("illop_decode", E_DECODE_ILL);
        op = 6'b000000; funct = 6'b000000;
        cyc("illop_next_fetch", E_FETCH_RDY);

        // illegal funct: pulse in EXECUTE, no write-back
        cyc("illfn_decode", E_DECODE);
        cyc("illfn_exec", E_EXEC_ILL);
        cyc("illfn_next_fetch", E_FETCH_RDY);

        // reset during a MEMWR wait
        op = 6'b101011;
        cyc("swr_decode", E_DECODE);
        cyc("swr_memadr", E_MEMADR);
        mem_ready = 1'b0;
        #2;
        check("swr_memwr_wait", {14'd0, outs}, {14'd0, E_MEMWR});
        reset_n = 1'b0;
        cyc("swr_memwr_in_reset", E_MEMWR_RST);
        cyc("swr_after_edge", E_RST_FETCH);
        reset_n = 1'b1;
        cyc("swr_fetch_wait", E_FETCH_WAIT);
        mem_ready = 1'b1;
        cyc("swr_fetch_rdy", E_FETCH_RDY);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
